tcdm_bank_amo_ctrl: RTL and testbench

Per-bank sequencer between the tile's TCDM slave port and one SRAM bank (1-cycle read latency). It executes plain loads and stores, and runs read-modify-write atomics as a two-cycle read/write-back sequence. It holds one LR/SC reservation per bank and buffers one response under backpressure. One instance per bank, NumBanksPerTile per tile.

---
 rtl/tcdm_bank_amo_ctrl_pkg.sv | 40 ++++
 rtl/tcdm_amo_alu.sv | 37 +++
 rtl/tcdm_bank_amo_ctrl.sv | 164 ++++++++++++++++
 tb/tb_tcdm_bank_amo_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcdm_bank_amo_ctrl_pkg.sv
// Shared types for the TCDM bank sequencer: AMO opcodes, FSM states and the
// LR/SC reservation record.
package tcdm_bank_amo_ctrl_pkg;

    typedef enum logic [3:0] {
        AMO_NONE = 4'h0,
        AMO_SWAP = 4'h1,
        AMO_ADD  = 4'h2,
        AMO_AND  = 4'h3,
        AMO_OR   = 4'h4,
        AMO_XOR  = 4'h5,
        AMO_MAX  = 4'h6,
        AMO_MAXU = 4'h7,
        AMO_MIN  = 4'h8,
        AMO_MINU = 4'h9,
        AMO_LR   = 4'hA,
        AMO_SC   = 4'hB
    } amo_t;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_AMO_WB = 1'b1
    } state_t;

    // Reservation fields are sized for the widest supported bank; narrower
    // addresses and core ids are zero-extended on the way in.
    localparam int unsigned ResAddrWidth   = 32;
    localparam int unsigned ResCoreIdWidth = 8;

    typedef struct packed {
        logic                      valid;
        logic [ResAddrWidth-1:0]   addr;
        logic [ResCoreIdWidth-1:0] core_id;
    } reservation_t;

    function automatic logic is_rmw_amo(input logic [3:0] amo);
        return (amo >= AMO_SWAP) && (amo <= AMO_MINU);
    endfunction

endpackage

// File: rtl/tcdm_amo_alu.sv
// Combinational read-modify-write operator for bank atomics; wrap-around
// arithmetic, signed MAX/MIN and unsigned MAXU/MINU.
module tcdm_amo_alu
    import tcdm_bank_amo_ctrl_pkg::*;
#(
    parameter int unsigned DataWidth = 32
) (
    input  logic [3:0]           amo,
    input  logic [DataWidth-1:0] old_data,
    input  logic [DataWidth-1:0] operand,
    output logic [DataWidth-1:0] new_data
);

    logic lt_signed_s;
    logic lt_unsigned_s;

    assign lt_signed_s   = $signed(old_data) < $signed(operand);
    assign lt_unsigned_s = old_data < operand;

    // Select the value written back for each atomic opcode
    always_comb begin
        new_data = old_data;
        case (amo)
            AMO_SWAP: new_data = operand;
            AMO_ADD:  new_data = old_data + operand;
            AMO_AND:  new_data = old_data & operand;
            AMO_OR:   new_data = old_data | operand;
            AMO_XOR:  new_data = old_data ^ operand;
            AMO_MAX:  new_data = lt_signed_s   ? operand  : old_data;
            AMO_MAXU: new_data = lt_unsigned_s ? operand  : old_data;
            AMO_MIN:  new_data = lt_signed_s   ? old_data : operand;
            AMO_MINU: new_data = lt_unsigned_s ? old_data : operand;
            default:  new_data = old_data;
        endcase
    end

endmodule

// File: rtl/tcdm_bank_amo_ctrl.sv
// Per-bank TCDM sequencer: loads, stores, two-cycle atomics and a one-deep
// response hold. LR/SC reservation is built only with TCDM_BANK_LRSC_EN.
module tcdm_bank_amo_ctrl
    import tcdm_bank_amo_ctrl_pkg::*;
#(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned AddrWidth   = 8,
    parameter int unsigned CoreIdWidth = 2,
    parameter int unsigned MetaWidth   = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [AddrWidth-1:0]   in_addr_i,
    input  logic                   in_wen_i,
    input  logic [DataWidth/8-1:0] in_be_i,
    input  logic [3:0]             in_amo_i,
    input  logic [DataWidth-1:0]   in_data_i,
    input  logic [CoreIdWidth-1:0] in_core_id_i,
    input  logic [MetaWidth-1:0]   in_meta_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DataWidth-1:0]   out_data_o,
    output logic [MetaWidth-1:0]   out_meta_o,
    output logic                   sram_req_o,
    output logic                   sram_we_o,
    output logic [AddrWidth-1:0]   sram_addr_o,
    output logic [DataWidth-1:0]   sram_wdata_o,
    output logic [DataWidth/8-1:0] sram_be_o,
    input  logic [DataWidth-1:0]   sram_rdata_i
);

    state_t                 state_r;
    logic                   out_valid_r;
    logic [MetaWidth-1:0]   out_meta_r;
    logic [DataWidth-1:0]   hold_r;
    logic                   use_hold_r;
    logic [AddrWidth-1:0]   wb_addr_r;
    logic [3:0]             wb_amo_r;
    logic [DataWidth-1:0]   wb_operand_r;

    logic                   accept_s;
    logic                   is_store_s;
    logic                   is_rmw_s;
    logic                   is_sc_s;
    logic                   sc_ok_s;
    logic                   respond_s;
    logic [DataWidth-1:0]   alu_result_s;

    assign in_ready_o  = (state_r == ST_IDLE) && (!out_valid_r || out_ready_i);
    assign accept_s    = in_valid_i && in_ready_o;
    assign is_store_s  = in_wen_i && (in_amo_i == AMO_NONE);
    assign is_rmw_s    = is_rmw_amo(in_amo_i);
    assign is_sc_s     = (in_amo_i == AMO_SC);
    assign respond_s   = accept_s && !is_store_s;

    assign out_valid_o = out_valid_r;
    assign out_meta_o  = out_meta_r;
    // First response cycle forwards the SRAM port; SC results and stalled data come from the hold register
    assign out_data_o  = use_hold_r ? hold_r : sram_rdata_i;

    tcdm_amo_alu #(
        .DataWidth (DataWidth)
    ) i_amo_alu (
        .amo      (wb_amo_r),
        .old_data (sram_rdata_i),
        .operand  (wb_operand_r),
        .new_data (alu_result_s)
    );

`ifdef TCDM_BANK_LRSC_EN
    reservation_t res_r;
    logic         is_lr_s;
    logic         res_hit_s;

    assign is_lr_s   = (in_amo_i == AMO_LR);
    assign res_hit_s = res_r.valid && (res_r.addr == ResAddrWidth'(in_addr_i));
    assign sc_ok_s   = res_hit_s && (res_r.core_id == ResCoreIdWidth'(in_core_id_i));

    // LR claims the reservation; SC, or any write to the reserved word, drops it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            res_r <= {$bits(reservation_t){1'b0}};
        end else if (accept_s && is_lr_s) begin
            res_r <= '{valid:   1'b1,
                       addr:    ResAddrWidth'(in_addr_i),
                       core_id: ResCoreIdWidth'(in_core_id_i)};
        end else if (accept_s && (is_sc_s || (is_store_s && res_hit_s))) begin
            res_r.valid <= 1'b0;
        end else if ((state_r == ST_AMO_WB) && (res_r.addr == ResAddrWidth'(wb_addr_r))) begin
            res_r.valid <= 1'b0;
        end else begin
            res_r <= res_r;
        end
    end
`else
    logic unused_core_id_s;

    assign sc_ok_s           = 1'b0;
    assign unused_core_id_s  = ^in_core_id_i;
`endif

    // SRAM port: atomic write-back wins, otherwise the accepted request goes straight through
    always_comb begin
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = in_addr_i;
        sram_wdata_o = in_data_i;
        sram_be_o    = in_be_i;
        if (state_r == ST_AMO_WB) begin
            sram_req_o   = 1'b1;
            sram_we_o    = 1'b1;
            sram_addr_o  = wb_addr_r;
            sram_wdata_o = alu_result_s;
            sram_be_o    = {(DataWidth/8){1'b1}};
        end else if (accept_s) begin
            sram_req_o   = 1'b1;
            sram_we_o    = is_store_s || (is_sc_s && sc_ok_s);
        end else begin
            sram_req_o   = 1'b0;
            sram_we_o    = 1'b0;
        end
    end

    // Sequencer state, response register and hold buffer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            out_valid_r  <= 1'b0;
            out_meta_r   <= {MetaWidth{1'b0}};
            hold_r       <= {DataWidth{1'b0}};
            use_hold_r   <= 1'b0;
            wb_addr_r    <= {AddrWidth{1'b0}};
            wb_amo_r     <= AMO_NONE;
            wb_operand_r <= {DataWidth{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE:   state_r <= (accept_s && is_rmw_s) ? ST_AMO_WB : ST_IDLE;
                ST_AMO_WB: state_r <= ST_IDLE;
                default:   state_r <= ST_IDLE;
            endcase

            if (accept_s) begin
                wb_addr_r    <= in_addr_i;
                wb_amo_r     <= in_amo_i;
                wb_operand_r <= in_data_i;
            end

            if (respond_s) begin
                out_valid_r <= 1'b1;
                out_meta_r  <= in_meta_i;
                use_hold_r  <= is_sc_s;
                hold_r      <= {{(DataWidth-1){1'b0}}, !sc_ok_s};
            end else if (out_valid_r && out_ready_i) begin
                out_valid_r <= 1'b0;
            end else if (out_valid_r && !use_hold_r) begin
                hold_r      <= sram_rdata_i;
                use_hold_r  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tcdm_bank_amo_ctrl.sv
// Self-checking bench for tcdm_bank_amo_ctrl: directed scenarios plus random
// traffic against a word-level memory/reservation model.
module tb_tcdm_bank_amo_ctrl;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int CW = 2;
    localparam int MW = 8;
    localparam int BW = DW / 8;

`ifdef TCDM_BANK_LRSC_EN
    localparam bit LrscEn = 1'b1;
`else
    localparam bit LrscEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic          in_wen;
    logic [BW-1:0] in_be;
    logic [3:0]    in_amo;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_core;
    logic [MW-1:0] in_meta;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [MW-1:0] out_meta;
    logic          sram_req;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [BW-1:0] sram_be;
    logic [DW-1:0] sram_rdata;

    logic [DW-1:0] sram_mem [256];
    logic          mem_clr;

    logic [DW-1:0] ref_mem [256];
    logic          res_valid;
    logic [AW-1:0] res_addr;
    logic [CW-1:0] res_core;
    int            n_tests = 0;
    int            n_fail  = 0;

    tcdm_bank_amo_ctrl #(
        .DataWidth(DW), .AddrWidth(AW), .CoreIdWidth(CW), .MetaWidth(MW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_addr_i(in_addr),
        .in_wen_i(in_wen), .in_be_i(in_be), .in_amo_i(in_amo), .in_data_i(in_data),
        .in_core_id_i(in_core), .in_meta_i(in_meta),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_meta_o(out_meta),
        .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
        .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
    );

    always #5 clk = ~clk;

    // SRAM with 1-cycle read latency; the read port shows garbage when not read
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) sram_mem[i] <= '0;
            sram_rdata <= '0;
        end else begin
            if (sram_req && !sram_we) sram_rdata <= sram_mem[sram_addr];
            else                      sram_rdata <= $urandom;
            if (sram_req && sram_we)
                for (int b = 0; b < BW; b++)
                    if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_alu(input logic [3:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        int sa = int'(a);
        int sb = int'(b);
        case (op)
            4'd1:    return b;
            4'd2:    return a + b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            4'd6:    return (sa > sb) ? a : b;
            4'd7:    return (a > b) ? a : b;
            4'd8:    return (sa < sb) ? a : b;
            4'd9:    return (a < b) ? a : b;
            default: return a;
        endcase
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r = old;
        for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Issue one request, update the model, and check the t+1 response.
    // Returns at #1 into the response cycle (or after the write-back for atomics).
    task automatic issue(input logic [AW-1:0] addr, input logic wen, input logic [BW-1:0] be,
                         input logic [3:0] amo, input logic [DW-1:0] data,
                         input logic [CW-1:0] core, input logic [MW-1:0] meta);
        logic          exp_resp;
        logic          rmw;
        logic [DW-1:0] exp_data;
        int            waits;
        @(negedge clk);
        in_valid = 1'b1; in_addr = addr; in_wen = wen; in_be = be;
        in_amo = amo; in_data = data; in_core = core; in_meta = meta;
        waits = 0;
        while (!in_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        check("accept", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        exp_resp = 1'b1;
        rmw      = 1'b0;
        exp_data = ref_mem[addr];
        if (amo == 4'd0 && wen) begin
            exp_resp = 1'b0;
            ref_mem[addr] = merge(ref_mem[addr], data, be);
            if (res_valid && res_addr == addr) res_valid = 1'b0;
        end else if (amo >= 4'd1 && amo <= 4'd9) begin
            rmw = 1'b1;
            ref_mem[addr] = ref_alu(amo, exp_data, data);
            if (res_valid && res_addr == addr) res_valid = 1'b0;
        end else if (amo == 4'hA) begin
            if (LrscEn) begin
                res_valid = 1'b1; res_addr = addr; res_core = core;
            end
        end else if (amo == 4'hB) begin
            if (LrscEn && res_valid && res_addr == addr && res_core == core) begin
                ref_mem[addr] = merge(ref_mem[addr], data, be);
                exp_data = 32'd0;
            end else begin
                exp_data = 32'd1;
            end
            res_valid = 1'b0;
        end

        if (exp_resp) begin
            check("resp_valid", {31'b0, out_valid}, 32'd1);
            check("resp_data", out_data, exp_data);
            check("resp_meta", {24'b0, out_meta}, {24'b0, meta});
        end else begin
            check("store_no_resp", {31'b0, out_valid}, 32'd0);
        end
        if (rmw) begin
            check("amo_busy", {31'b0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
            check("amo_done", {31'b0, in_ready}, 32'd1);
        end
    endtask

    initial begin
        logic [DW-1:0] bp_data;
        int            waits;
        rst = 1'b1; mem_clr = 1'b1; out_ready = 1'b1;
        in_valid = 1'b0; in_addr = '0; in_wen = 1'b0; in_be = '0; in_amo = 4'd0;
        in_data = '0; in_core = '0; in_meta = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        res_valid = 1'b0; res_addr = '0; res_core = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_sram_req", {31'b0, sram_req}, 32'd0);
        check("rst_sram_we", {31'b0, sram_we}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        mem_clr = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Load after store
        issue(8'h10, 1'b1, 4'hF, 4'd0, 32'hDEADBEEF, 2'd0, 8'h11);
        issue(8'h10, 1'b0, 4'h0, 4'd0, 32'h0, 2'd0, 8'h12);
        check("load_deadbeef", out_data, 32'hDEADBEEF);

        // AMO ADD wrap-around
        issue(8'h20, 1'b1, 4'hF, 4'd0, 32'hFFFFFFFF, 2'd0, 8'h20);
        issue(8'h20, 1'b0, 4'hF, 4'd2, 32'd2, 2'd0, 8'h21);
        issue(8'h20, 1'b0, 4'h0, 4'd0, 32'h0, 2'd0, 8'h22);
        check("add_wrap", out_data, 32'h00000001);

        // Signed MAX vs unsigned MAXU
        issue(8'h40, 1'b1, 4'hF, 4'd0, 32'h80000000, 2'd0, 8'h40);
        issue(8'h40, 1'b0, 4'hF, 4'd6, 32'd1, 2'd0, 8'h41);
        issue(8'h40, 1'b0, 4'h0, 4'd0, 32'h0, 2'd0, 8'h42);
        check("max_signed", out_data, 32'h00000001);
        issue(8'h44, 1'b1, 4'hF, 4'd0, 32'h80000000, 2'd0, 8'h44);
        issue(8'h44, 1'b0, 4'hF, 4'd7, 32'd1, 2'd0, 8'h45);
        issue(8'h44, 1'b0, 4'h0, 4'd0, 32'h0, 2'd0, 8'h46);
        check("maxu_unsigned", out_data, 32'h80000000);

        // LR/SC success, then broken by another core's store
        issue(8'h30, 1'b0, 4'h0, 4'hA, 32'h0, 2'd1, 8'h30);
        issue(8'h30, 1'b0, 4'hF, 4'hB, 32'h5, 2'd1, 8'h31);
        check("sc_success", out_data, LrscEn ? 32'd0 : 32'd1);
        issue(8'h30, 1'b0, 4'h0, 4'd0, 32'h0, 2'd1, 8'h32);
        check("sc_mem", out_data, LrscEn ? 32'h5 : 32'h0);
        issue(8'h30, 1'b0, 4'h0, 4'hA, 32'h0, 2'd1, 8'h33);
        issue(8'h30, 1'b1, 4'hF, 4'd0, 32'h77, 2'd2, 8'h34);
        issue(8'h30, 1'b0, 4'hF, 4'hB, 32'h9, 2'd1, 8'h35);
        check("sc_broken", out_data, 32'd1);
        issue(8'h30, 1'b0, 4'h0, 4'd0, 32'h0, 2'd1, 8'h36);
        check("sc_broken_mem", out_data, 32'h77);

        // Backpressure: response held for three cycles while the SRAM port churns
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue(8'h10, 1'b0, 4'h0, 4'd0, 32'h0, 2'd0, 8'h5A);
        bp_data = ref_mem[8'h10];
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_data", out_data, bp_data);
            check("bp_valid", {31'b0, out_valid}, 32'd1);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("bp_consumed", {31'b0, out_valid}, 32'd0);

        // Reset during the AMO write-back cycle
        issue(8'h50, 1'b0, 4'h0, 4'hA, 32'h0, 2'd1, 8'h50);
        issue(8'h60, 1'b1, 4'hF, 4'd0, 32'h00001234, 2'd0, 8'h51);
        @(negedge clk);
        in_valid = 1'b1; in_addr = 8'h60; in_wen = 1'b0; in_be = 4'hF;
        in_amo = 4'd2; in_data = 32'd5; in_core = 2'd0; in_meta = 8'h52;
        waits = 0;
        while (!in_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        check("rst_amo_accept", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_amo_req", {31'b0, sram_req}, 32'd0);
        check("rst_amo_we", {31'b0, sram_we}, 32'd0);
        check("rst_amo_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        res_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_amo_mem", sram_mem[8'h60], ref_mem[8'h60]);
        issue(8'h50, 1'b0, 4'hF, 4'hB, 32'hABCD, 2'd1, 8'h53);
        check("sc_after_rst", out_data, 32'd1);

        // Random traffic over a small window so reservations and atomics collide
        for (int i = 0; i < 300; i++) begin
            issue(AW'(8'h80 + $urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  BW'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), DW'($urandom),
                  CW'($urandom_range(0, 3)), MW'($urandom_range(0, 255)));
        end

        @(posedge clk);
        #1;
        for (int i = 0; i < 256; i++) check("mem_final", sram_mem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
